fetch_decode_reg: RTL and testbench
===================================

FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

Parameters
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), giving the bubble instruction.
REQ-003 The block SHALL have parameter MAX_STALL, default 1, giving the longest legal run of consecutive stall cycles.

Interface
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr_in  in  32  instruction word read combinationally from instruction memory at pc_f.
REQ-007 pc_target  in  32  branch/jump target from execute stage.
REQ-008 stall  in  1  load-use stall from hazard detection; freezes fetch and the decode register.
REQ-009 flush  in  1  taken-branch flush from hazard detection; redirects fetch and kills the decode entry.
REQ-010 pc_f  out  32  current fetch PC, drives instruction memory address.
REQ-011 pc_d  out  32  PC of the instruction held for decode/execute.
REQ-012 instr_d  out  32  instruction held for decode/execute.
REQ-013 valid_d  out  1  1 when instr_d is a real instruction; 0 for a bubble.
REQ-014 stall_count  out  32  number of cycles spent stalled.
REQ-015 flush_count  out  32  number of flush cycles.
REQ-016 stall_err  out  1  sticky flag: stall held longer than MAX_STALL consecutive cycles.

Function
REQ-017 The block SHALL evaluate, each cycle, with priority rst > flush > stall > advance.
REQ-018 On advance, the block SHALL load pc_f <= pc_f+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), pc_d <= pc_f, instr_d <= instr_in, valid_d <= 1.
REQ-019 On stall without flush, the block SHALL hold pc_f, pc_d, instr_d and valid_d unchanged.
REQ-020 On flush, the block SHALL load pc_f <= {pc_target[31:2],2'b00}, instr_d <= NOP_INSTR, valid_d <= 0, and SHALL hold pc_d unchanged.
REQ-021 On flush and stall in the same cycle, the block SHALL apply flush only and SHALL NOT count the cycle as stalled.
REQ-022 The block SHALL implement FSM states FILL, RUN and HOLD.
REQ-023 FILL SHALL be entered on reset; the first non-reset cycle SHALL transition to RUN (advance/flush) or HOLD (stall).
REQ-024 The FSM SHALL move RUN->HOLD on stall&!flush, HOLD->HOLD while stall&!flush, and HOLD->RUN on !stall or flush.
REQ-025 A 2-bit saturating run counter SHALL count consecutive HOLD cycles; it SHALL clear on leaving HOLD.
REQ-026 stall_err SHALL set in the cycle after the run counter exceeds MAX_STALL, and SHALL remain 1 until reset.
REQ-027 stall_count SHALL increment by 1 on each stall&!flush cycle, and SHALL saturate at 32'hFFFF_FFFF.
REQ-028 flush_count SHALL increment by 1 on each flush cycle, and SHALL saturate at 32'hFFFF_FFFF.
REQ-029 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL set pc_f=RESET_PC, pc_d=0, instr_d=NOP_INSTR, valid_d=0, stall_count=0, flush_count=0, stall_err=0, run counter=0 and state=FILL, regardless of stall or flush.
REQ-031 Reset asserted mid-stall or mid-flush SHALL discard that operation entirely.

Verification
REQ-032 Reset then 3 advance cycles, instr_in=0x00A00093,0x00100113,0x002081B3 -> pc_f=0x0,0x4,0x8,0xC; instr_d follows one cycle later with pc_d=0x0,0x4,0x8; valid_d=1 from cycle 2.
REQ-033 Stall for 1 cycle at pc_f=0x8 -> pc_f, pc_d, instr_d held for that cycle; stall_count=1; stall_err=0; advance resumes with pc_f=0xC.
REQ-034 flush=1 with pc_target=0x0000_0103 at pc_f=0x10 -> next pc_f=0x100, instr_d=0x00000013, valid_d=0, pc_d unchanged, flush_count=1.
REQ-035 flush=1 and stall=1 together with pc_target=0x40 -> pc_f=0x40, valid_d=0, stall_count unchanged, flush_count incremented.
REQ-036 stall held 3 consecutive cycles with MAX_STALL=1 -> stall_err=1 and stays 1 after stall drops; rst=1 for one cycle -> all outputs return to reset values.
REQ-037 Preload pc_f=0xFFFF_FFFC via flush, then advance -> pc_f=0x0000_0000.

Source files
------------

// File: rtl/fetch_decode_reg.sv
// Fetch PC generator and IF/ID pipeline register with stall/flush handling and hazard counters.
// Latency: one cycle from instr_in/pc_f to instr_d/pc_d; all outputs come straight from flops.
// Backpressure: stall freezes fetch and the decode register; flush redirects fetch and inserts a bubble.
module fetch_decode_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          MAX_STALL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_target,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic        stall_err
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_run_cnt;
    logic [1:0]  w_run_cnt_nxt;
    logic        w_stall_eff;
    logic        w_run_over;

    logic [31:0] r_pc_f;
    logic [31:0] r_pc_d;
    logic [31:0] r_instr_d;
    logic        r_valid_d;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        r_stall_err;

    // A flush always wins over a simultaneous stall.
    assign w_stall_eff = stall & ~flush;
    assign w_run_over  = int'({30'd0, r_run_cnt}) > MAX_STALL;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: every state heads to HOLD on an effective stall and to RUN otherwise.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  w_state_nxt = w_stall_eff ? S_HOLD : S_RUN;
            S_RUN:   w_state_nxt = w_stall_eff ? S_HOLD : S_RUN;
            S_HOLD:  w_state_nxt = w_stall_eff ? S_HOLD : S_RUN;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Run counter tracks consecutive HOLD cycles, saturating at 3 and clearing on exit.
    always_comb begin
        w_run_cnt_nxt = 2'd0;
        if (w_state_nxt == S_HOLD) begin
            w_run_cnt_nxt = (r_run_cnt == 2'd3) ? 2'd3 : r_run_cnt + 2'd1;
        end
    end

    // Run counter and sticky over-long-stall flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt   <= 2'd0;
            r_stall_err <= 1'b0;
        end else begin
            r_run_cnt <= w_run_cnt_nxt;
            if (w_run_over) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    // Fetch PC and decode register: flush > stall > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f    <= RESET_PC;
            r_pc_d    <= 32'd0;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (flush) begin
            r_pc_f    <= {pc_target[31:2], 2'b00};
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!stall) begin
            r_pc_f    <= r_pc_f + 32'd4;
            r_pc_d    <= r_pc_f;
            r_instr_d <= instr_in;
            r_valid_d <= 1'b1;
        end
    end

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_eff && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign pc_f        = r_pc_f;
    assign pc_d        = r_pc_d;
    assign instr_d     = r_instr_d;
    assign valid_d     = r_valid_d;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
    assign stall_err   = r_stall_err;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: scenario tasks push expected register state per cycle.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall and flush driven directly from the stimulus rows.
module tb_fetch_decode_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic [31:0] instr_d;
        logic        valid_d;
        logic [31:0] stall_count;
        logic [31:0] flush_count;
        logic        stall_err;
    } exp_t;

    typedef struct {
        logic        r;
        logic        st;
        logic        fl;
        logic [31:0] tgt;
        exp_t        e;
    } row_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic [31:0] pc_target;
    logic        stall;
    logic        flush;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic        stall_err;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    fetch_decode_reg #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP),
        .MAX_STALL(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .pc_target  (pc_target),
        .stall      (stall),
        .flush      (flush),
        .pc_f       (pc_f),
        .pc_d       (pc_d),
        .instr_d    (instr_d),
        .valid_d    (valid_d),
        .stall_count(stall_count),
        .flush_count(flush_count),
        .stall_err  (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: three fixed words, a pattern elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   imem = 32'h00A0_0093;
            32'h4:   imem = 32'h0010_0113;
            32'h8:   imem = 32'h0020_81B3;
            default: imem = a ^ 32'h1357_0000;
        endcase
    endfunction

    always_comb instr_in = imem(pc_f);

    function automatic exp_t mk(input logic [31:0] pf, pd, ins, input logic v,
                                input logic [31:0] sc, fc, input logic er);
        mk = '{pc_f: pf, pc_d: pd, instr_d: ins, valid_d: v,
               stall_count: sc, flush_count: fc, stall_err: er};
    endfunction

    function automatic row_t rw(input logic r, st, fl, input logic [31:0] tgt, input exp_t e);
        rw = '{r: r, st: st, fl: fl, tgt: tgt, e: e};
    endfunction

    function automatic exp_t sample();
        sample = mk(pc_f, pc_d, instr_d, valid_d, stall_count, flush_count, stall_err);
    endfunction

    // Drive one cycle of stimulus and record what the registers must hold afterwards.
    task automatic step(input row_t row);
        rst       = row.r;
        stall     = row.st;
        flush     = row.fl;
        pc_target = row.tgt;
        exp_q.push_back(row.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t got, e;
        rows.push_back(rw(1, 1, 1, 32'h40, mk(0, 0, NOP, 0, 0, 0, 0)));
        foreach (rows[i]) begin
            step(rows[i]);
            got = sample();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL reset[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL reset[%0d]: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_advance_stall();
        row_t rows[$];
        exp_t got, e;
        rows.push_back(rw(0, 0, 0, 0, mk(32'h4,  32'h0, 32'h00A0_0093, 1, 0, 0, 0)));
        rows.push_back(rw(0, 0, 0, 0, mk(32'h8,  32'h4, 32'h0010_0113, 1, 0, 0, 0)));
        rows.push_back(rw(0, 1, 0, 0, mk(32'h8,  32'h4, 32'h0010_0113, 1, 1, 0, 0)));
        rows.push_back(rw(0, 0, 0, 0, mk(32'hC,  32'h8, 32'h0020_81B3, 1, 1, 0, 0)));
        rows.push_back(rw(0, 0, 0, 0, mk(32'h10, 32'hC, imem(32'hC),   1, 1, 0, 0)));
        foreach (rows[i]) begin
            step(rows[i]);
            got = sample();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL advance_stall[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL advance_stall[%0d]: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        exp_t got, e;
        rows.push_back(rw(0, 0, 1, 32'h0000_0103, mk(32'h100, 32'hC,   NOP,          0, 1, 1, 0)));
        rows.push_back(rw(0, 0, 0, 32'h0,         mk(32'h104, 32'h100, imem(32'h100), 1, 1, 1, 0)));
        rows.push_back(rw(0, 1, 1, 32'h40,        mk(32'h40,  32'h100, NOP,          0, 1, 2, 0)));
        rows.push_back(rw(0, 0, 0, 32'h0,         mk(32'h44,  32'h40,  imem(32'h40),  1, 1, 2, 0)));
        foreach (rows[i]) begin
            step(rows[i]);
            got = sample();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL flush[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL flush[%0d]: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_stall_err();
        row_t rows[$];
        exp_t got, e;
        rows.push_back(rw(0, 1, 0, 0, mk(32'h44, 32'h40, imem(32'h40), 1, 2, 2, 0)));
        rows.push_back(rw(0, 1, 0, 0, mk(32'h44, 32'h40, imem(32'h40), 1, 3, 2, 0)));
        rows.push_back(rw(0, 1, 0, 0, mk(32'h44, 32'h40, imem(32'h40), 1, 4, 2, 1)));
        rows.push_back(rw(0, 0, 0, 0, mk(32'h48, 32'h44, imem(32'h44), 1, 4, 2, 1)));
        rows.push_back(rw(0, 0, 0, 0, mk(32'h4C, 32'h48, imem(32'h48), 1, 4, 2, 1)));
        foreach (rows[i]) begin
            step(rows[i]);
            got = sample();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL stall_err[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL stall_err[%0d]: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        exp_t got, e;
        rows.push_back(rw(0, 0, 1, 32'hFFFF_FFFF, mk(32'hFFFF_FFFC, 32'h48, NOP, 0, 4, 3, 1)));
        rows.push_back(rw(0, 0, 0, 32'h0, mk(32'h0, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 1, 4, 3, 1)));
        rows.push_back(rw(0, 0, 0, 32'h0, mk(32'h4, 32'h0, 32'h00A0_0093, 1, 4, 3, 1)));
        foreach (rows[i]) begin
            step(rows[i]);
            got = sample();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL wrap[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL wrap[%0d]: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        exp_t got, e;
        rows.push_back(rw(1, 1, 0, 32'h0,  mk(0, 0, NOP, 0, 0, 0, 0)));
        rows.push_back(rw(0, 1, 0, 32'h0,  mk(0, 0, NOP, 0, 1, 0, 0)));
        rows.push_back(rw(1, 0, 1, 32'h80, mk(0, 0, NOP, 0, 0, 0, 0)));
        rows.push_back(rw(0, 1, 0, 32'h0,  mk(0, 0, NOP, 0, 1, 0, 0)));
        rows.push_back(rw(0, 1, 0, 32'h0,  mk(0, 0, NOP, 0, 2, 0, 0)));
        rows.push_back(rw(0, 0, 0, 32'h0,  mk(32'h4, 32'h0, 32'h00A0_0093, 1, 2, 0, 1)));
        foreach (rows[i]) begin
            step(rows[i]);
            got = sample();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL reset_mid[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++; $display("FAIL reset_mid[%0d]: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        pc_target = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_advance_stall();
        test_flush();
        test_stall_err();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
